// File: rtl/fir_out_decimator_if.sv
// Sample stream around the FIR output decimator.
// master = the decimator; slave = the FIR producer and the downstream consumer.
interface fir_out_decimator_if #(
  parameter int DW = 16
);
  logic          s_en;
  logic [DW-1:0] in_sample;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport master (
    input  s_en,
    input  in_sample,
    input  m_ready,
    output m_valid,
    output m_data
  );

  modport slave (
    output s_en,
    output in_sample,
    output m_ready,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fir_out_decimator.sv
// Drops FIR warm-up samples, keeps every DEC-th sample and buffers it in a FWFT FIFO.
// Optional build macro FIRDEC_DROP_CNT_EN adds a saturating drop_cnt output.
module fir_out_decimator #(
  parameter int DW     = 16,
  parameter int DEC    = 4,
  parameter int WARMUP = 13,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  fir_out_decimator_if.master      bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef FIRDEC_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic {
    ST_WARMUP,
    ST_RUN
  } state_t;

  // With no warm-up to discard, the block comes out of reset already decimating.
  localparam state_t RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t          state_q, state_d;
  logic [WW-1:0]   warm_q, warm_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            push_req;

  logic [DW-1:0]   sample;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   count_q;
  logic            full;
  logic            not_empty;
  logic            do_push;
  logic            do_pop;
  logic            drop;

  assign sample = bus.in_sample;

  // ---------------------------------------------------------------------------
  // Warm-up / decimation phase control
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      warm_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      phase_q <= phase_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    phase_d  = phase_q;
    push_req = 1'b0;
    case (state_q)
      ST_WARMUP: begin
        if (bus.s_en) begin
          if (warm_q == WW'(WARMUP - 1)) begin
            state_d = ST_RUN;
          end
          warm_d = warm_q + WW'(1);
        end
      end
      ST_RUN: begin
        if (bus.s_en) begin
          push_req = (phase_q == '0);
          phase_d  = (phase_q == PW'(DEC - 1)) ? '0 : phase_q + PW'(1);
        end
      end
      default: state_d = RESET_STATE;
    endcase
    // Flush realigns decimation but leaves the warm-up tracking alone: the
    // FIR history it models is not affected by emptying our buffer.
    if (flush) begin
      phase_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign full      = (count_q == LW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign do_pop    = not_empty & bus.m_ready & ~flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push_req & ~flush & (~full | do_pop);
  assign drop      = push_req & ~flush & full & ~do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and occupancy do,
  // and m_data is forced to zero while empty so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= sample;
    end
  end

  assign bus.m_valid = not_empty;
  assign bus.m_data  = not_empty ? mem[rd_ptr] : '0;
  assign level       = count_q;

  // ---------------------------------------------------------------------------
  // Drop reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef FIRDEC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_level_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= LW'(DEPTH));

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    do_pop |-> not_empty);

  a_push_has_room : assert property (@(posedge clk) disable iff (!rst_n)
    do_push |-> (!full || do_pop));

endmodule

// File: tb/tb_fir_out_decimator.sv
// Self-checking bench: a DEC=4 and a DEC=1 decimator side by side, a queue
// scoreboard checked every cycle, plus a vector table and hand sequences.
module tb_fir_out_decimator;

  localparam int DW     = 16;
  localparam int WARMUP = 13;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0: DEC=4, index 1: DEC=1)
  logic          s_en      [2];
  logic [DW-1:0] in_sample [2];
  logic          m_ready   [2];
  logic          flush     [2];

  // Per-instance observed outputs
  logic [DW-1:0] dout_a  [2];
  logic          valid_a [2];
  logic [LW-1:0] level_a [2];
  logic          ovf_a   [2];
  logic [LW-1:0] lvl0, lvl1;
  logic          ovf0, ovf1;
`ifdef FIRDEC_DROP_CNT_EN
  logic [7:0]    dcnt_a  [2];
  logic [7:0]    dcnt0, dcnt1;
`endif

  fir_out_decimator_if #(.DW(DW)) bus0 ();
  fir_out_decimator_if #(.DW(DW)) bus1 ();

  assign bus0.s_en      = s_en[0];
  assign bus0.in_sample = in_sample[0];
  assign bus0.m_ready   = m_ready[0];
  assign bus1.s_en      = s_en[1];
  assign bus1.in_sample = in_sample[1];
  assign bus1.m_ready   = m_ready[1];

  assign dout_a[0]  = bus0.m_data;
  assign dout_a[1]  = bus1.m_data;
  assign valid_a[0] = bus0.m_valid;
  assign valid_a[1] = bus1.m_valid;
  assign level_a[0] = lvl0;
  assign level_a[1] = lvl1;
  assign ovf_a[0]   = ovf0;
  assign ovf_a[1]   = ovf1;
`ifdef FIRDEC_DROP_CNT_EN
  assign dcnt_a[0]  = dcnt0;
  assign dcnt_a[1]  = dcnt1;
`endif

  fir_out_decimator #(.DW(DW), .DEC(4), .WARMUP(WARMUP), .DEPTH(DEPTH)) u_dec4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush[0]),
    .bus      (bus0.master),
    .level    (lvl0),
    .overflow (ovf0)
`ifdef FIRDEC_DROP_CNT_EN
    ,
    .drop_cnt (dcnt0)
`endif
  );

  fir_out_decimator #(.DW(DW), .DEC(1), .WARMUP(WARMUP), .DEPTH(DEPTH)) u_dec1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush[1]),
    .bus      (bus1.master),
    .level    (lvl1),
    .overflow (ovf1)
`ifdef FIRDEC_DROP_CNT_EN
    ,
    .drop_cnt (dcnt1)
`endif
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping and reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  int            m_warm  [2];
  bit            m_run   [2];
  int            m_phase [2];
  bit            m_ovf   [2];
  int            m_drops [2];
  logic [DW-1:0] q0[$], q1[$];
  logic [DW-1:0] seen0[$], seen1[$];
  int            max_lvl1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int q_size(input int i);
    if (i == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic logic [DW-1:0] q_head(input int i);
    if (i == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void q_push(input int i, input logic [DW-1:0] v);
    if (i == 0) q0.push_back(v);
    else q1.push_back(v);
  endfunction

  function automatic logic [DW-1:0] q_pop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void seen_push(input int i, input logic [DW-1:0] v);
    if (i == 0) seen0.push_back(v);
    else seen1.push_back(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_warm[i]  = 0;
      m_run[i]   = (WARMUP == 0);
      m_phase[i] = 0;
      m_ovf[i]   = 1'b0;
      m_drops[i] = 0;
    end
    q0.delete();
    q1.delete();
  endfunction

  // Called just before a clock edge with the stimulus for that edge applied.
  task automatic model_edge(input int i);
    bit            push_req;
    bit            pop;
    logic [DW-1:0] v;
    push_req = m_run[i] && s_en[i] && (m_phase[i] == 0);
    pop      = (q_size(i) > 0) && m_ready[i] && !flush[i];
    if (s_en[i]) begin
      if (!m_run[i]) begin
        if (m_warm[i] == WARMUP - 1) m_run[i] = 1'b1;
        m_warm[i]++;
      end else begin
        m_phase[i] = (m_phase[i] + 1) % dec_of(i);
      end
    end
    if (flush[i]) begin
      if (i == 0) q0.delete();
      else q1.delete();
      m_phase[i] = 0;
      m_ovf[i]   = 1'b0;
      m_drops[i] = 0;
    end else begin
      if (pop) begin
        v = q_pop(i);
        check($sformatf("u%0d pop data", i), 32'(dout_a[i]), 32'(v));
        seen_push(i, v);
      end
      if (push_req) begin
        if (q_size(i) < DEPTH) begin
          q_push(i, in_sample[i]);
        end else begin
          m_ovf[i] = 1'b1;
          if (m_drops[i] < 255) m_drops[i]++;
        end
      end
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < 2; i++) model_edge(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d level", i), 32'(level_a[i]), 32'(q_size(i)));
      check($sformatf("u%0d m_valid", i), 32'(valid_a[i]), 32'(q_size(i) > 0));
      check($sformatf("u%0d overflow", i), 32'(ovf_a[i]), 32'(m_ovf[i]));
      if (q_size(i) > 0)
        check($sformatf("u%0d head data", i), 32'(dout_a[i]), 32'(q_head(i)));
`ifdef FIRDEC_DROP_CNT_EN
      check($sformatf("u%0d drop_cnt", i), 32'(dcnt_a[i]), 32'(m_drops[i]));
`endif
    end
    if (int'(level_a[1]) > max_lvl1) max_lvl1 = int'(level_a[1]);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      s_en[i]      = 1'b0;
      in_sample[i] = '0;
      m_ready[i]   = 1'b0;
      flush[i]     = 1'b0;
    end
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d reset level", i), 32'(level_a[i]), 32'd0);
      check($sformatf("u%0d reset m_valid", i), 32'(valid_a[i]), 32'd0);
      check($sformatf("u%0d reset m_data", i), 32'(dout_a[i]), 32'd0);
      check($sformatf("u%0d reset overflow", i), 32'(ovf_a[i]), 32'd0);
`ifdef FIRDEC_DROP_CNT_EN
      check($sformatf("u%0d reset drop_cnt", i), 32'(dcnt_a[i]), 32'd0);
`endif
    end
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the DEC=1 instance: fill, drop, full push+pop, flush
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            s_en;
    logic [DW-1:0] din;
    bit            rdy;
    bit            fl;
    int            lvl;
    bit            vld;
    logic [DW-1:0] dat;
    bit            ovf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_v0;
    int first_v1;

    tbl[0] = '{1'b1, 16'd100, 1'b0, 1'b0, 1, 1'b1, 16'd100, 1'b0};
    for (int i = 1; i < 8; i++)
      tbl[i] = '{1'b1, 16'(100 + i), 1'b0, 1'b0, i + 1, 1'b1, 16'd100, 1'b0};
    tbl[8]  = '{1'b1, 16'd108, 1'b0, 1'b0, 8, 1'b1, 16'd100, 1'b1};
    tbl[9]  = '{1'b1, 16'd109, 1'b1, 1'b0, 8, 1'b1, 16'd101, 1'b1};
    tbl[10] = '{1'b0, 16'd0,   1'b1, 1'b0, 7, 1'b1, 16'd102, 1'b1};
    tbl[11] = '{1'b1, 16'd110, 1'b1, 1'b0, 7, 1'b1, 16'd103, 1'b1};
    tbl[12] = '{1'b1, 16'd111, 1'b1, 1'b1, 0, 1'b0, 16'd0,   1'b0};
    tbl[13] = '{1'b1, 16'd112, 1'b1, 1'b0, 1, 1'b1, 16'd112, 1'b0};
    tbl[14] = '{1'b0, 16'd0,   1'b1, 1'b0, 0, 1'b0, 16'd0,   1'b0};

    idle_inputs();
    max_lvl1 = 0;
    #2;
    async_reset();

    // Continuous stream into DEC=4; alternating strobe into DEC=1.
    first_v0 = -1;
    first_v1 = -1;
    seen0.delete();
    seen1.delete();
    max_lvl1 = 0;
    for (int k = 0; k < 61; k++) begin
      s_en[0] = 1'b1; in_sample[0] = 16'(k); m_ready[0] = 1'b1;
      s_en[1] = (k % 2 == 0); in_sample[1] = 16'(k); m_ready[1] = 1'b1;
      cycle();
      if (valid_a[0] && first_v0 < 0) first_v0 = k;
      if (valid_a[1] && first_v1 < 0) first_v1 = k;
    end
    check("u0 first valid cycle", 32'(first_v0), 32'd13);
    check("u1 first valid cycle", 32'(first_v1), 32'd26);
    check("u0 output count", 32'(seen0.size()), 32'd12);
    foreach (seen0[j]) check($sformatf("u0 stream[%0d]", j), 32'(seen0[j]), 32'(13 + 4 * j));
    check("u1 output count", 32'(seen1.size()), 32'd17);
    foreach (seen1[j]) check($sformatf("u1 stream[%0d]", j), 32'(seen1[j]), 32'(26 + 2 * j));
    check("u1 max level", 32'(max_lvl1), 32'd1);

    idle_inputs();
    m_ready[1] = 1'b1;
    cycle();

    for (int r = 0; r < 15; r++) begin
      idle_inputs();
      s_en[1]      = tbl[r].s_en;
      in_sample[1] = tbl[r].din;
      m_ready[1]   = tbl[r].rdy;
      flush[1]     = tbl[r].fl;
      cycle();
      check($sformatf("vec%0d level", r), 32'(level_a[1]), 32'(tbl[r].lvl));
      check($sformatf("vec%0d m_valid", r), 32'(valid_a[1]), 32'(tbl[r].vld));
      if (tbl[r].vld) check($sformatf("vec%0d m_data", r), 32'(dout_a[1]), 32'(tbl[r].dat));
      check($sformatf("vec%0d overflow", r), 32'(ovf_a[1]), 32'(tbl[r].ovf));
    end

    // DEC=4 overflow then full drain.
    idle_inputs();
    flush[0] = 1'b1;
    cycle();
    flush[0] = 1'b0;
    for (int k = 0; k < 36; k++) begin
      s_en[0] = 1'b1; in_sample[0] = 16'(1000 + k); m_ready[0] = 1'b0;
      cycle();
    end
    check("ovf fill level", 32'(level_a[0]), 32'd8);
    check("ovf sticky set", 32'(ovf_a[0]), 32'd1);
`ifdef FIRDEC_DROP_CNT_EN
    check("ovf drop_cnt", 32'(dcnt_a[0]), 32'd1);
`endif
    seen0.delete();
    for (int k = 0; k < 8; k++) begin
      s_en[0] = 1'b0; m_ready[0] = 1'b1;
      cycle();
    end
    check("drain count", 32'(seen0.size()), 32'd8);
    foreach (seen0[j]) check($sformatf("drain[%0d]", j), 32'(seen0[j]), 32'(1000 + 4 * j));
    check("drain level", 32'(level_a[0]), 32'd0);
    check("drain overflow kept", 32'(ovf_a[0]), 32'd1);

    // Refill to 5, flush, then the very next enabled sample must be kept.
    for (int k = 0; k < 17; k++) begin
      s_en[0] = 1'b1; in_sample[0] = 16'(2000 + k); m_ready[0] = 1'b0;
      cycle();
    end
    check("pre-flush level", 32'(level_a[0]), 32'd5);
    s_en[0] = 1'b0; m_ready[0] = 1'b1; flush[0] = 1'b1;
    cycle();
    flush[0] = 1'b0;
    check("flush level", 32'(level_a[0]), 32'd0);
    check("flush m_valid", 32'(valid_a[0]), 32'd0);
    check("flush overflow", 32'(ovf_a[0]), 32'd0);
    s_en[0] = 1'b1; in_sample[0] = 16'd3000; m_ready[0] = 1'b0;
    cycle();
    check("post-flush level", 32'(level_a[0]), 32'd1);
    check("post-flush m_data", 32'(dout_a[0]), 32'd3000);

    // Mid-stream async reset with level 3, then warm-up must restart.
    idle_inputs();
    flush[0] = 1'b1;
    cycle();
    flush[0] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      s_en[0] = 1'b1; in_sample[0] = 16'(4000 + k); m_ready[0] = 1'b0;
      cycle();
    end
    check("pre-reset level", 32'(level_a[0]), 32'd3);
    async_reset();
    first_v0 = -1;
    seen0.delete();
    for (int k = 0; k < 20; k++) begin
      s_en[0] = 1'b1; in_sample[0] = 16'(500 + k); m_ready[0] = 1'b1;
      cycle();
      if (valid_a[0] && first_v0 < 0) first_v0 = k;
    end
    check("rewarm first valid cycle", 32'(first_v0), 32'd13);
    check("rewarm output count", 32'(seen0.size()), 32'd2);
    if (seen0.size() > 0) check("rewarm first value", 32'(seen0[0]), 32'd513);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
